// File: rtl/dpram_arb_pkg.sv
// Shared types and constants for the dual-port RAM arbiter.
package dpram_arb_pkg;
  localparam int unsigned AW       = 2;
  localparam int unsigned DW       = 4;
  localparam int unsigned NREQ_MAX = 8;
  localparam int unsigned IDW      = $clog2(NREQ_MAX);

  typedef logic [IDW-1:0] req_id_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;
endpackage

// File: rtl/dpram_arbiter_rr_pick.sv
// Rotating-priority finder: first set bit of mask scanning from ptr, wrapping at N.
module rr_pick
  import dpram_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] mask,
  input  req_id_t      ptr,
  output logic         found,
  output req_id_t      index
);
  localparam int unsigned PW = IDW + 1;

  logic [NREQ_MAX-1:0] mask_ext;
  logic [PW-1:0]       pos;

  assign mask_ext = NREQ_MAX'(mask);

  always_comb begin
    found = 1'b0;
    index = '0;
    pos   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + PW'(i);
      if (pos >= PW'(N)) pos = pos - PW'(N);
      if (!found && mask_ext[pos[IDW-1:0]]) begin
        found = 1'b1;
        index = pos[IDW-1:0];
      end
    end
  end
endmodule

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter granting up to two non-conflicting requests per cycle onto
// the two ports of a shared dual-port RAM, with fixed-latency read returns.
module dpram_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = dpram_arb_pkg::AW,
  parameter int unsigned DW   = dpram_arb_pkg::DW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [NREQ*DW-1:0] rsp_rdata,
  output logic             wea,
  output logic             web,
  output logic [AW-1:0]    addra,
  output logic [AW-1:0]    addrb,
  output logic [DW-1:0]    dina,
  output logic [DW-1:0]    dinb,
  input  logic [DW-1:0]    douta,
  input  logic [DW-1:0]    doutb
);
  import dpram_arb_pkg::*;

  localparam int unsigned PW = IDW + 1;

  req_id_t         ptr;
  req_id_t         win_a, win_b;
  logic            found_a, found_b;
  logic [NREQ-1:0] valid_m, mask_b;

  logic            sel_we_a, sel_we_b;
  logic [AW-1:0]   sel_addr_a, sel_addr_b;
  logic [DW-1:0]   sel_din_a, sel_din_b;

  rd_tag_t         pipe [2][2];
  rd_tag_t         tag_a, tag_b;

  assign valid_m = req_valid & {NREQ{rst_n}};

  rr_pick #(.N(NREQ)) u_pick_a (
    .mask  (valid_m),
    .ptr   (ptr),
    .found (found_a),
    .index (win_a)
  );

  // Winner B scans the same order; winner A and anything conflicting with it are removed.
  rr_pick #(.N(NREQ)) u_pick_b (
    .mask  (mask_b),
    .ptr   (ptr),
    .found (found_b),
    .index (win_b)
  );

  always_comb begin
    sel_we_a   = 1'b0;
    sel_addr_a = '0;
    sel_din_a  = '0;
    sel_we_b   = 1'b0;
    sel_addr_b = '0;
    sel_din_b  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_a == req_id_t'(i)) begin
        sel_we_a   = req_we[i];
        sel_addr_a = req_addr[i*AW +: AW];
        sel_din_a  = req_wdata[i*DW +: DW];
      end
      if (win_b == req_id_t'(i)) begin
        sel_we_b   = req_we[i];
        sel_addr_b = req_addr[i*AW +: AW];
        sel_din_b  = req_wdata[i*DW +: DW];
      end
    end
  end

  assign tag_a = pipe[PORT_A][1];
  assign tag_b = pipe[PORT_B][1];

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    assign mask_b[g] = valid_m[g] & found_a & (win_a != req_id_t'(g)) &
                       ~((req_addr[g*AW +: AW] == sel_addr_a) & (req_we[g] | sel_we_a));

    assign req_ready[g] = (found_a & (win_a == req_id_t'(g))) |
                          (found_b & (win_b == req_id_t'(g)));

    assign rsp_valid[g] = (tag_a.valid & (tag_a.id == req_id_t'(g))) |
                          (tag_b.valid & (tag_b.id == req_id_t'(g)));

    assign rsp_rdata[g*DW +: DW] = (tag_a.valid & (tag_a.id == req_id_t'(g))) ? douta :
                                   (tag_b.valid & (tag_b.id == req_id_t'(g))) ? doutb : '0;
  end

  function automatic req_id_t wrap_inc(input req_id_t id);
    logic [PW-1:0] s;
    s = {1'b0, id} + PW'(1);
    if (s >= PW'(NREQ)) s = '0;
    return s[IDW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr   <= '0;
      wea   <= 1'b0;
      web   <= 1'b0;
      addra <= '0;
      addrb <= '0;
      dina  <= '0;
      dinb  <= '0;
      pipe[PORT_A][0] <= '0;
      pipe[PORT_A][1] <= '0;
      pipe[PORT_B][0] <= '0;
      pipe[PORT_B][1] <= '0;
    end else begin
      if (found_b)      ptr <= wrap_inc(win_b);
      else if (found_a) ptr <= wrap_inc(win_a);

      wea <= found_a & sel_we_a;
      if (found_a) begin
        addra <= sel_addr_a;
        dina  <= sel_din_a;
      end
      web <= found_b & sel_we_b;
      if (found_b) begin
        addrb <= sel_addr_b;
        dinb  <= sel_din_b;
      end

      pipe[PORT_A][0] <= '{valid: found_a & ~sel_we_a, id: win_a};
      pipe[PORT_A][1] <= pipe[PORT_A][0];
      pipe[PORT_B][0] <= '{valid: found_b & ~sel_we_b, id: win_b};
      pipe[PORT_B][1] <= pipe[PORT_B][0];
    end
  end
endmodule
